// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and the fetch-queue entry layout.
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h00000013
`endif
`ifndef RESET_PC_DEFAULT
`define RESET_PC_DEFAULT 32'h00000000
`endif

package fetch_stage_pkg;

    localparam logic [31:0] NOP = `NOP_INSTRUCTION;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: DEPTH x {fault, pc, instr} queue with flush and push+pop when full.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d  = flush_i ? '0 : (do_push ? wr_q + AW'(1) : wr_q);
        rd_d  = flush_i ? '0 : (do_pop ? rd_q + AW'(1) : rd_q);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; count gates visibility of stale slots.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, fetch queue push/redirect control and misaligned-fetch fault.
// Optional: FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = `RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        fetch_fault_o
);
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, full, empty;
    fetch_entry_t wr_entry, head;

    assign pop         = id_valid_o & id_ready_i;
    assign push        = fetch_en_i & ~redirect_i & (~full | pop);
    assign imem_addr_o = pc_q;
    assign id_valid_o  = ~empty;
    assign id_pc_o     = empty ? 32'h0 : head.pc;
    assign id_instr_o  = empty ? NOP : head.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d  = redirect_i ? |redirect_pc_i[1:0] : fault_q;
        pc_d     = redirect_i ? redirect_pc_i : ((push && !fault_q) ? pc_q + 32'd4 : pc_q);
        wr_entry = '{fault: fault_q, pc: pc_q, instr: fault_q ? NOP : imem_instr_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fetch_fault_o = ~empty & head.fault;
`else
    logic unused_bits;

    always_comb begin
        pc_d     = redirect_i ? {redirect_pc_i[31:2], 2'b00} : (push ? pc_q + 32'd4 : pc_q);
        wr_entry = '{fault: 1'b0, pc: pc_q, instr: imem_instr_i};
    end

    assign unused_bits   = ^{redirect_pc_i[1:0], head.fault};
    assign fetch_fault_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  (wr_entry),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule
